// File: rtl/seq_divider8.sv
// seq_divider8 -- sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request pulse; X/Y sampled when accepted (IDLE or DONE only)
//   X            dividend
//   Y            divisor
//   Quo          quotient, registered, held until the next done
//   Rem          remainder, registered, held until the next done
//   busy         high while iterating
//   done         one-cycle pulse when Quo/Rem are valid
//   div_by_zero  high with done when Y was 0; held until the next accepted start
//   chk_err      sticky result self-check mismatch flag
//
// Optional feature: define DIV_SELFCHECK_EN to build a Quo*V+Rem == X checker
// driving chk_err. Without it, chk_err is tied low.
module seq_divider8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Quo,
  output logic [WIDTH-1:0] Rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             chk_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] v_q, v_d;      // divisor
  logic [WIDTH-1:0] r_q, r_d;      // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] d_step;
  logic             accept;
  logic             last_iter;

  // One restoring step, evaluated every cycle and used only in RUN.
  always_comb begin
    t      = {r_q, d_q[WIDTH-1]};
    ge     = (t >= {1'b0, v_q});
    diff   = t - {1'b0, v_q};
    // When T >= V the difference is below V, so it fits in WIDTH bits.
    r_step = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    d_step = {d_q[WIDTH-2:0], ge};
  end

  assign accept    = start && (state_q != S_RUN);
  assign last_iter = (state_q == S_RUN) && (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_RUN: begin
        d_d   = d_step;
        r_d   = r_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          quo_d   = d_step;
          rem_d   = r_step;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          if (Y == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = X;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            d_d     = X;
            v_d     = Y;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            dbz_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIV_SELFCHECK_EN
  logic [WIDTH-1:0]   xorig_q, xorig_d;
  logic               chk_q, chk_d;
  logic [2*WIDTH-1:0] recon;

  // Check the values being loaded into Quo/Rem so chk_err rises with done.
  always_comb begin
    xorig_d = xorig_q;
    if (accept && (Y != '0)) xorig_d = X;
    recon = ({{WIDTH{1'b0}}, quo_d} * {{WIDTH{1'b0}}, v_q}) + {{WIDTH{1'b0}}, rem_d};
    chk_d = chk_q;
    if (last_iter && (recon != {{WIDTH{1'b0}}, xorig_q})) chk_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xorig_q <= '0;
      chk_q   <= 1'b0;
    end else begin
      xorig_q <= xorig_d;
      chk_q   <= chk_d;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

  assign Quo         = quo_q;
  assign Rem         = rem_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;

endmodule
